// File: rtl/console_uart_rx.sv
// Console UART receiver: 16x oversampled 8N1 (or 8E1) deserializer feeding a
// show-ahead byte FIFO, with sticky frame/overrun/parity error flags.
// Optional feature macro: CONSOLE_RX_PARITY_EN selects 8E1 framing with a
// PARITY state; without it framing is 8N1 and parity_err is tied low.
module console_uart_rx #(
  parameter int DIV   = 256,
  parameter int DEPTH = 8
) (
  input  logic                     sysclk,
  input  logic                     sys_rst_n,
  input  logic                     rxd,
  input  logic                     rd_ready,
  input  logic                     err_clr,
  output logic                     rd_valid,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     parity_err,
  output logic                     rx_active
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
  localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef CONSOLE_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_e;

  state_e      state_q, state_d;
  logic        rxd_s1_q, rxd_s2_q;
  logic        rxd_s;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic        tick;
  logic [3:0]  sub_q, sub_d;     // ticks since last sample point
  logic [2:0]  bit_q, bit_d;     // data bit index
  logic [7:0]  sh_q, sh_d;       // LSB-first shift register
  logic        push;
  logic        fe_set;

  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] cnt_q, cnt_d;
  logic        pop, full, accept_push, ovr_set;
  logic        fe_q, ovr_q;

  assign rxd_s = rxd_s2_q;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
    end else begin
      rxd_s1_q <= rxd;
      rxd_s2_q <= rxd_s1_q;
    end
  end

  // Oversample divider: held at 0 in IDLE so a start edge restarts it
  assign tick = (div_cnt_q == DIV_M1);
  always_comb begin
    div_cnt_d = div_cnt_q + 16'd1;
    if (state_q == S_IDLE || tick) div_cnt_d = 16'd0;
  end

  // Frame state and datapath registers
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      div_cnt_q <= 16'd0;
      sub_q     <= 4'd0;
      bit_q     <= 3'd0;
      sh_q      <= 8'h00;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      sub_q     <= sub_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
    end
  end

`ifdef CONSOLE_RX_PARITY_EN
  logic pe_set;
  logic pe_q;
`endif

  // Next-state: start at mid-bit (tick 8), then one sample every 16 ticks
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    push    = 1'b0;
    fe_set  = 1'b0;
`ifdef CONSOLE_RX_PARITY_EN
    pe_set  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxd_s) begin
          state_d = S_START;
          sub_d   = 4'd0;
        end
      end
      S_START: begin
        if (tick) begin
          if (sub_q == 4'd7) begin
            sub_d   = 4'd0;
            bit_d   = 3'd0;
            state_d = rxd_s ? S_IDLE : S_DATA;
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (sub_q == 4'd15) begin
            sh_d  = {rxd_s, sh_q[7:1]};
            sub_d = 4'd0;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef CONSOLE_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
      end
`ifdef CONSOLE_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (sub_q == 4'd15) begin
            pe_set  = ^{sh_q, rxd_s};
            sub_d   = 4'd0;
            state_d = S_STOP;
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (sub_q == 4'd15) begin
            sub_d = 4'd0;
            if (rxd_s) begin
              push    = 1'b1;
              state_d = S_IDLE;
            end else begin
              fe_set  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
      end
      S_BREAK: begin
        if (rxd_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_active = (state_q != S_IDLE);

  // FIFO control: a push on a full FIFO is accepted only with a same-cycle pop
  assign rd_valid    = (cnt_q != '0);
  assign pop         = rd_valid & rd_ready;
  assign full        = (cnt_q == FULL);
  assign accept_push = push & (~full | pop);
  assign ovr_set     = push & full & ~pop;

  always_comb begin
    cnt_d = cnt_q;
    case ({accept_push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)         rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage (no reset needed; reads are masked by rd_valid)
  always_ff @(posedge sysclk) begin
    if (accept_push) mem_q[wr_ptr_q] <= sh_q;
  end

  assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count = cnt_q;

  // Sticky error flags; a set event wins over a coincident clear
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fe_q  <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      fe_q  <= fe_set  | (fe_q  & ~err_clr);
      ovr_q <= ovr_set | (ovr_q & ~err_clr);
    end
  end

  assign frame_err = fe_q;
  assign overrun   = ovr_q;

`ifdef CONSOLE_RX_PARITY_EN
  // Sticky parity error flag
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) pe_q <= 1'b0;
    else            pe_q <= pe_set | (pe_q & ~err_clr);
  end
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_console_uart_rx.sv
// Bench for console_uart_rx at DIV=4 (64 clocks per bit), DEPTH=8.
module tb_console_uart_rx;

  localparam int DIV   = 4;
  localparam int DEPTH = 8;
  localparam int BITC  = 16 * DIV;
`ifdef CONSOLE_RX_PARITY_EN
  localparam int STOP_EDGE = 675;
`else
  localparam int STOP_EDGE = 611;
`endif

  logic       sysclk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rd_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [3:0] fifo_count;
  logic       frame_err, overrun, parity_err, rx_active;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
`ifdef CONSOLE_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  console_uart_rx #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .sysclk(sysclk), .sys_rst_n(sys_rst_n), .rxd(rxd), .rd_ready(rd_ready),
    .err_clr(err_clr), .rd_valid(rd_valid), .rd_data(rd_data),
    .fifo_count(fifo_count), .frame_err(frame_err), .overrun(overrun),
    .parity_err(parity_err), .rx_active(rx_active)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Serial frame driver; the scoreboard predicts the push at stop-sample time
  task automatic send_frame(input logic [7:0] d, input logic stop_val,
                            input int stop_clks, input bit pop_at_stop);
    int prev;
    int n;
    int exp_cnt;
    logic [7:0] e;
    prev = int'(fifo_count);
    n = 0;
    rxd = 1'b0;
    repeat (BITC) begin @(negedge sysclk); n++; end
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BITC) begin @(negedge sysclk); n++; end
    end
`ifdef CONSOLE_RX_PARITY_EN
    rxd = (^d) ^ par_flip;
    repeat (BITC) begin @(negedge sysclk); n++; end
`endif
    rxd = stop_val;
    for (int i = 0; i < stop_clks; i++) begin
      @(negedge sysclk); n++;
      if (n == STOP_EDGE - 1) begin
        checks++;
        if (fifo_count !== 4'(prev)) begin
          errors++;
          $display("FAIL pre_stop_count: got %0d want %0d", fifo_count, prev);
        end
        if (pop_at_stop) begin
          e = q.pop_front();
          checks++;
          if (rd_data !== e) begin
            errors++;
            $display("FAIL stop_pop_data: got %h want %h", rd_data, e);
          end
          rd_ready = 1'b1;
        end
      end
      if (n == STOP_EDGE) begin
        rd_ready = 1'b0;
        if (stop_val) begin
          if (pop_at_stop)       exp_cnt = prev;
          else if (prev < DEPTH) exp_cnt = prev + 1;
          else                   exp_cnt = prev;
          if (pop_at_stop || prev < DEPTH) q.push_back(d);
        end else begin
          exp_cnt = prev;
          checks++;
          if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL frame_err_set: got %b want 1", frame_err);
          end
        end
        checks++;
        if (fifo_count !== 4'(exp_cnt)) begin
          errors++;
          $display("FAIL post_stop_count: got %0d want %0d", fifo_count, exp_cnt);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge sysclk);
  endtask

  // Pop one byte and compare it against the scoreboard head
  task automatic read_one();
    int t;
    logic [7:0] e;
    t = 0;
    while (rd_valid !== 1'b1 && t < 200) begin @(negedge sysclk); t++; end
    checks++;
    if (rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL read_timeout: rd_valid got %b want 1", rd_valid);
    end else if (q.size() == 0) begin
      errors++;
      $display("FAIL read_extra: got %h want no data", rd_data);
    end else begin
      e = q.pop_front();
      if (rd_data !== e) begin
        errors++;
        $display("FAIL read_data: got %h want %h", rd_data, e);
      end
    end
    rd_ready = 1'b1;
    @(negedge sysclk);
    rd_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge sysclk);
    err_clr = 1'b0;
    @(negedge sysclk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sysclk);
    checks++;
    if ({rd_valid, rd_data, fifo_count, frame_err, overrun, parity_err, rx_active} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %b %h %0d %b %b %b %b want all 0",
               rd_valid, rd_data, fifo_count, frame_err, overrun, parity_err, rx_active);
    end
    sys_rst_n = 1'b1;
    idle(10);
  endtask

  task automatic test_two_bytes();
    send_frame(8'h55, 1'b1, BITC, 1'b0);
    idle(20);
    send_frame(8'hA3, 1'b1, BITC, 1'b0);
    idle(20);
    read_one();
    checks++;
    if (fifo_count !== 4'd1) begin
      errors++;
      $display("FAIL count_after_read1: got %0d want 1", fifo_count);
    end
    read_one();
    checks++;
    if (fifo_count !== 4'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL count_after_read2: got %0d/%b want 0/0", fifo_count, rd_valid);
    end
  endtask

  task automatic test_glitch();
    rxd = 1'b0;
    repeat (8) @(negedge sysclk);
    checks++;
    if (rx_active !== 1'b1) begin
      errors++;
      $display("FAIL glitch_active: got %b want 1", rx_active);
    end
    repeat (4) @(negedge sysclk);
    idle(60);
    checks++;
    if ({rx_active, fifo_count, frame_err, overrun, parity_err} !== 8'h0) begin
      errors++;
      $display("FAIL glitch_idle: got act=%b cnt=%0d fe=%b ov=%b pe=%b want all 0",
               rx_active, fifo_count, frame_err, overrun, parity_err);
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'h7E, 1'b0, 160, 1'b0);
    checks++;
    if (rx_active !== 1'b1 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL break_hold: got act=%b cnt=%0d want 1/0", rx_active, fifo_count);
    end
    idle(10);
    checks++;
    if (rx_active !== 1'b0 || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL break_exit: got act=%b fe=%b want 0/1", rx_active, frame_err);
    end
    pulse_clr();
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_clr: got %b want 0", frame_err);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 1'b1, BITC, 1'b0);
      idle(10);
    end
    checks++;
    if (overrun !== 1'b1 || fifo_count !== 4'd8) begin
      errors++;
      $display("FAIL overrun_full: got ov=%b cnt=%0d want 1/8", overrun, fifo_count);
    end
    for (int i = 0; i < 8; i++) read_one();
    checks++;
    if (fifo_count !== 4'd0 || q.size() != 0) begin
      errors++;
      $display("FAIL overrun_drain: got cnt=%0d left=%0d want 0/0", fifo_count, q.size());
    end
    pulse_clr();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clr: got %b want 0", overrun);
    end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 8; i++) begin
      send_frame(8'(i), 1'b1, BITC, 1'b0);
      idle(10);
    end
    send_frame(8'h08, 1'b1, BITC, 1'b1);
    idle(10);
    checks++;
    if (overrun !== 1'b0 || fifo_count !== 4'd8) begin
      errors++;
      $display("FAIL full_pop: got ov=%b cnt=%0d want 0/8", overrun, fifo_count);
    end
    for (int i = 0; i < 8; i++) read_one();
    checks++;
    if (fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL full_pop_drain: got %0d want 0", fifo_count);
    end
  endtask

`ifdef CONSOLE_RX_PARITY_EN
  task automatic test_parity();
    par_flip = 1'b1;
    send_frame(8'h01, 1'b1, BITC, 1'b0);
    par_flip = 1'b0;
    idle(10);
    checks++;
    if (parity_err !== 1'b1) begin
      errors++;
      $display("FAIL parity_err_set: got %b want 1", parity_err);
    end
    read_one();
    pulse_clr();
    checks++;
    if (parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_err_clr: got %b want 0", parity_err);
    end
  endtask
`endif

  task automatic test_reset_mid();
    send_frame(8'h3C, 1'b1, BITC, 1'b0);
    idle(10);
    rxd = 1'b0;
    repeat (300) @(negedge sysclk);
    checks++;
    if (rx_active !== 1'b1 || fifo_count !== 4'd1) begin
      errors++;
      $display("FAIL mid_frame_pre: got act=%b cnt=%0d want 1/1", rx_active, fifo_count);
    end
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_valid, rd_data, fifo_count, frame_err, overrun, parity_err, rx_active} !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b %h %0d %b %b %b %b want all 0",
               rd_valid, rd_data, fifo_count, frame_err, overrun, parity_err, rx_active);
    end
    q.delete();
    rxd = 1'b1;
    repeat (3) @(negedge sysclk);
    sys_rst_n = 1'b1;
    idle(700);
    checks++;
    if ({rd_valid, fifo_count, frame_err, overrun, parity_err, rx_active} !== 9'h0) begin
      errors++;
      $display("FAIL mid_reset_after: got v=%b cnt=%0d fe=%b ov=%b pe=%b act=%b want all 0",
               rd_valid, fifo_count, frame_err, overrun, parity_err, rx_active);
    end
  endtask

  initial begin
    test_reset();
    test_two_bytes();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_full_pop();
`ifdef CONSOLE_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/console_uart_rx.md
CONSOLE_UART_RX -- requirements
Module: console_uart_rx

Interface
REQ-001 SHALL have parameter DIV, default 256, system clocks per 1/16 bit (39.3216 MHz / (9600*16)); legal range 2..65535.
REQ-002 SHALL have parameter DEPTH, default 8, receive FIFO entries; power of two, 2..64.
REQ-003 SHALL have port sysclk, input, 1, the single clock; all state is clocked on its rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rxd, input, 1, serial line from the CPU board TXD; asynchronous to sysclk; idles high.
REQ-006 SHALL have port rd_ready, input, 1, consumer accepts the head byte.
REQ-007 SHALL have port err_clr, input, 1, clears the sticky error flags.
REQ-008 SHALL have port rd_valid, output, 1, FIFO not empty.
REQ-009 SHALL have port rd_data, output, 8, head-of-FIFO byte, valid while rd_valid=1.
REQ-010 SHALL have port fifo_count, output, $clog2(DEPTH)+1, number of stored bytes.
REQ-011 SHALL have ports frame_err, overrun and parity_err, outputs, 1 each, sticky error flags.
REQ-012 SHALL have port rx_active, output, 1, high while a frame is being received (any state except IDLE).

Function
REQ-013 SHALL pass rxd through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-014 SHALL generate a tick every DIV clocks; the tick counter restarts at 0 on the start-edge detect.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY (only when compiled in), STOP and BREAK.
REQ-016 IDLE: synchronized rxd=0 SHALL transition to START.
REQ-017 START: rxd SHALL be sampled on tick 8; rxd=1 is a false start and returns to IDLE with no flags; rxd=0 goes to DATA.
REQ-018 DATA: 8 bits SHALL be sampled LSB first, each 16 ticks after the previous sample.
REQ-019 STOP: the stop bit SHALL be sampled 16 ticks after the last data or parity sample; rxd=1 pushes the byte and returns to IDLE.
REQ-020 A stop sample of 0 SHALL set frame_err, discard the byte and enter BREAK; BREAK returns to IDLE on the first synchronized rxd=1.
REQ-021 A pushed byte SHALL appear on rd_valid/rd_data on the clock after the stop-sample cycle.
REQ-022 The FIFO SHALL be show-ahead; a pop occurs on a clock where rd_valid=1 and rd_ready=1.
REQ-023 rd_ready while empty SHALL have no effect.
REQ-024 A push with the FIFO full and no pop in the same clock SHALL drop the byte and set overrun; stored data is unchanged.
REQ-025 A push and a pop in the same clock SHALL both be accepted, including when full; fifo_count is then unchanged.
REQ-026 Pointers SHALL wrap modulo DEPTH; fifo_count SHALL range 0..DEPTH.
REQ-027 Error flags SHALL be sticky until err_clr=1; if a set event and err_clr coincide, the flag SHALL remain set.

Reset
REQ-028 Asserting sys_rst_n=0 SHALL immediately force state=IDLE, FIFO empty, and tick counter and synchronizer flops to their idle values (synchronizer flops =1).
REQ-029 During reset the outputs SHALL be rd_valid=0, rd_data=0, fifo_count=0, frame_err=0, overrun=0, parity_err=0 and rx_active=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no push and no flag.
REQ-031 After reset release, a line that is already low SHALL be treated as a start edge.

Configuration
REQ-032 Macro CONSOLE_RX_PARITY_EN defined SHALL select 8E1 framing: PARITY is sampled 16 ticks after bit 7, and odd total ones sets parity_err.
REQ-033 A byte with a parity error SHALL still be pushed when its stop bit is good.
REQ-034 Without CONSOLE_RX_PARITY_EN, framing SHALL be 8N1, there SHALL be no PARITY state, and parity_err SHALL be tied to 0.

Verification
REQ-035 DIV=4, 8N1, send 0x55 then 0xA3 -> rd_valid rises 1 clock after each stop sample; reads return 0x55 then 0xA3; fifo_count steps 1, 2, 1, 0.
REQ-036 Low glitch of 3 ticks on idle rxd -> return to IDLE; no push; no flags.
REQ-037 Send 0x7E with the stop bit held low for 40 ticks -> frame_err=1, fifo_count=0, no second byte decoded until rxd returns high; err_clr pulse -> frame_err=0.
REQ-038 DEPTH=8, rd_ready=0, send 9 bytes 0x00..0x08 -> overrun=1, fifo_count=8, reads yield 0x00..0x07.
REQ-039 FIFO full, rd_ready=1 held during the 9th stop sample -> overrun=0, fifo_count stays 8, last byte read is 0x08.
REQ-040 CONSOLE_RX_PARITY_EN defined: send 0x01 with parity bit 0 -> parity_err=1 and 0x01 is pushed; reset pulsed mid-frame -> all outputs 0 and FIFO empty.
